sram_packet_ctrl: RTL and testbench

//  Parametrised successor to the two-macro packet decoder: accepts one command packet per transaction

---
 rtl/sram_packet_ctrl_pkg.sv | 44 ++++
 rtl/sram_packet_ctrl_if.sv | 24 ++
 rtl/sram_packet_ctrl_decode.sv | 44 ++++
 rtl/sram_packet_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_sram_packet_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_packet_ctrl_pkg.sv
// Shared opcodes, FSM encoding and packet field layout helpers for the SRAM packet controller.
package sram_packet_ctrl_pkg;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_READ_RW   = 3'd2;
    localparam logic [2:0] OP_READ_RO   = 3'd3;
    localparam logic [2:0] OP_READ_DUAL = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Packet is {op, bank, wmask, addr, wdata, addr_ro} with addr_ro in the low bits.
    function automatic int bankWidth(input int numSrams);
        return (numSrams > 1) ? $clog2(numSrams) : 1;
    endfunction

    function automatic int pktWidth(input int bankW, input int maskW, input int addrW, input int dataW);
        return 3 + bankW + maskW + 2 * addrW + dataW;
    endfunction

    function automatic int offWdata(input int addrW);
        return addrW;
    endfunction

    function automatic int offAddr(input int addrW, input int dataW);
        return addrW + dataW;
    endfunction

    function automatic int offWmask(input int addrW, input int dataW);
        return 2 * addrW + dataW;
    endfunction

    function automatic int offBank(input int addrW, input int dataW, input int maskW);
        return 2 * addrW + dataW + maskW;
    endfunction

    function automatic int offOp(input int addrW, input int dataW, input int maskW, input int bankW);
        return 2 * addrW + dataW + maskW + bankW;
    endfunction

endpackage

// File: rtl/sram_packet_ctrl_if.sv
// Packet request / response channel between the packet source (master) and the controller (slave).
interface sram_packet_ctrl_if #(
    parameter int PKT_W      = 56,
    parameter int DATA_WIDTH = 32
);
    logic                  pkt_valid;
    logic                  pkt_ready;
    logic [PKT_W-1:0]      packet;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_data_rw;
    logic [DATA_WIDTH-1:0] rsp_data_ro;

    modport master (
        output pkt_valid, packet, rsp_ready,
        input  pkt_ready, rsp_valid, rsp_err, rsp_data_rw, rsp_data_ro
    );

    modport slave (
        input  pkt_valid, packet, rsp_ready,
        output pkt_ready, rsp_valid, rsp_err, rsp_data_rw, rsp_data_ro
    );
endinterface

// File: rtl/sram_packet_ctrl_decode.sv
// Combinational packet field split plus legality and port-usage flags.
module sram_packet_ctrl_decode
    import sram_packet_ctrl_pkg::*;
#(
    parameter int  NUM_SRAMS  = 2,
    parameter int  ADDR_WIDTH = 8,
    parameter int  DATA_WIDTH = 32,
    parameter int  MASK_WIDTH = 4,
    localparam int BANK_W     = bankWidth(NUM_SRAMS),
    localparam int PKT_W      = pktWidth(BANK_W, MASK_WIDTH, ADDR_WIDTH, DATA_WIDTH)
) (
    input  logic [PKT_W-1:0]      packet_i,
    output logic [BANK_W-1:0]     bank_o,
    output logic [MASK_WIDTH-1:0] wmask_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [ADDR_WIDTH-1:0] addrRo_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  isNop_o,
    output logic                  isWrite_o,
    output logic                  legal_o,
    output logic                  usePort0_o,
    output logic                  usePort1_o
);
    logic [2:0] op;
    logic       isRead;

    assign op       = packet_i[offOp(ADDR_WIDTH, DATA_WIDTH, MASK_WIDTH, BANK_W) +: 3];
    assign bank_o   = packet_i[offBank(ADDR_WIDTH, DATA_WIDTH, MASK_WIDTH) +: BANK_W];
    assign wmask_o  = packet_i[offWmask(ADDR_WIDTH, DATA_WIDTH) +: MASK_WIDTH];
    assign addr_o   = packet_i[offAddr(ADDR_WIDTH, DATA_WIDTH) +: ADDR_WIDTH];
    assign wdata_o  = packet_i[offWdata(ADDR_WIDTH) +: DATA_WIDTH];
    assign addrRo_o = packet_i[ADDR_WIDTH-1:0];

    // A NOP is dropped silently, so its bank field is never checked.
    always_comb begin
        isNop_o    = (op == OP_NOP);
        isWrite_o  = (op == OP_WRITE);
        isRead     = (op == OP_READ_RW) || (op == OP_READ_RO) || (op == OP_READ_DUAL);
        usePort0_o = isWrite_o || (op == OP_READ_RW) || (op == OP_READ_DUAL);
        usePort1_o = (op == OP_READ_RO) || (op == OP_READ_DUAL);
        legal_o    = isNop_o || ((isWrite_o || isRead) && (32'(bank_o) < 32'(NUM_SRAMS)));
    end

endmodule

// File: rtl/sram_packet_ctrl.sv
// Packet-driven controller for an array of 1rw1r SRAM macros: one transaction at a time,
// single-cycle macro strobe, programmable read latency and a held response channel.
module sram_packet_ctrl
    import sram_packet_ctrl_pkg::*;
#(
    parameter int NUM_SRAMS    = 2,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                             clk_in,
    input  logic                             rst,
    sram_packet_ctrl_if.slave                pktBus,
    output logic [NUM_SRAMS-1:0]             sram_csb0,
    output logic [NUM_SRAMS-1:0]             sram_web0,
    output logic [NUM_SRAMS*MASK_WIDTH-1:0]  sram_wmask0,
    output logic [NUM_SRAMS*ADDR_WIDTH-1:0]  sram_addr0,
    output logic [NUM_SRAMS*DATA_WIDTH-1:0]  sram_din0,
    input  logic [NUM_SRAMS*DATA_WIDTH-1:0]  sram_dout0,
    output logic [NUM_SRAMS-1:0]             sram_csb1,
    output logic [NUM_SRAMS*ADDR_WIDTH-1:0]  sram_addr1,
    input  logic [NUM_SRAMS*DATA_WIDTH-1:0]  sram_dout1,
    output logic                             busy
);
    localparam int BANK_W = bankWidth(NUM_SRAMS);
    localparam int LAT_W  = 2;

    logic [BANK_W-1:0]     dBank;
    logic [MASK_WIDTH-1:0] dWmask;
    logic [ADDR_WIDTH-1:0] dAddr, dAddrRo;
    logic [DATA_WIDTH-1:0] dWdata;
    logic                  dNop, dWrite, dLegal, dPort0, dPort1;

    logic [1:0]                      state_q, state_d;
    logic [LAT_W-1:0]                latCnt_q, latCnt_d;
    logic [BANK_W-1:0]               bank_q, bank_d;
    logic                            port0_q, port0_d, port1_q, port1_d, write_q, write_d;
    logic [NUM_SRAMS-1:0]            csb0_q, csb0_d, csb1_q, csb1_d, web0_q, web0_d;
    logic [NUM_SRAMS*MASK_WIDTH-1:0] wmask0_q, wmask0_d;
    logic [NUM_SRAMS*ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [NUM_SRAMS*DATA_WIDTH-1:0] din0_q, din0_d;
    logic                            rspValid_q, rspValid_d, rspErr_q, rspErr_d;
    logic [DATA_WIDTH-1:0]           rspRw_q, rspRw_d, rspRo_q, rspRo_d;
    logic [DATA_WIDTH-1:0]           doutRw, doutRo;
    logic                            pktReady, accept;

    sram_packet_ctrl_decode #(
        .NUM_SRAMS (NUM_SRAMS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .MASK_WIDTH(MASK_WIDTH)
    ) uDecode (
        .packet_i  (pktBus.packet),
        .bank_o    (dBank),
        .wmask_o   (dWmask),
        .addr_o    (dAddr),
        .addrRo_o  (dAddrRo),
        .wdata_o   (dWdata),
        .isNop_o   (dNop),
        .isWrite_o (dWrite),
        .legal_o   (dLegal),
        .usePort0_o(dPort0),
        .usePort1_o(dPort1)
    );

    assign pktReady = (state_q == ST_IDLE) && !rst;
    assign accept   = pktBus.pkt_valid && pktReady;

    always_comb begin
        doutRw = '0;
        doutRo = '0;
        for (int i = 0; i < NUM_SRAMS; i++) begin
            if (int'(bank_q) == i) begin
                doutRw = sram_dout0[i*DATA_WIDTH +: DATA_WIDTH];
                doutRo = sram_dout1[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Strobes default back to idle every cycle, so csb/web are low only in the ISSUE cycle.
    always_comb begin
        state_d    = state_q;
        latCnt_d   = latCnt_q;
        bank_d     = bank_q;
        port0_d    = port0_q;
        port1_d    = port1_q;
        write_d    = write_q;
        csb0_d     = '1;
        csb1_d     = '1;
        web0_d     = '1;
        wmask0_d   = wmask0_q;
        addr0_d    = addr0_q;
        addr1_d    = addr1_q;
        din0_d     = din0_q;
        rspValid_d = rspValid_q;
        rspErr_d   = rspErr_q;
        rspRw_d    = rspRw_q;
        rspRo_d    = rspRo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !dNop) begin
                    bank_d  = dBank;
                    port0_d = dPort0;
                    port1_d = dPort1;
                    write_d = dWrite;
                    if (!dLegal) begin
                        state_d    = ST_RESP;
                        rspValid_d = 1'b1;
                        rspErr_d   = 1'b1;
                        rspRw_d    = '0;
                        rspRo_d    = '0;
                    end else begin
                        state_d = ST_ISSUE;
                        for (int i = 0; i < NUM_SRAMS; i++) begin
                            if (int'(dBank) == i) begin
                                if (dPort0) begin
                                    csb0_d[i]                           = 1'b0;
                                    addr0_d[i*ADDR_WIDTH +: ADDR_WIDTH] = dAddr;
                                end
                                if (dPort1) begin
                                    csb1_d[i]                           = 1'b0;
                                    addr1_d[i*ADDR_WIDTH +: ADDR_WIDTH] = dAddrRo;
                                end
                                if (dWrite) begin
                                    web0_d[i]                            = 1'b0;
                                    wmask0_d[i*MASK_WIDTH +: MASK_WIDTH] = dWmask;
                                    din0_d[i*DATA_WIDTH +: DATA_WIDTH]   = dWdata;
                                end
                            end
                        end
                    end
                end
            end
            ST_ISSUE: begin
                if (write_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_WAIT;
                    latCnt_d = LAT_W'(READ_LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (latCnt_q == '0) begin
                    state_d    = ST_RESP;
                    rspValid_d = 1'b1;
                    rspErr_d   = 1'b0;
                    rspRw_d    = port0_q ? doutRw : '0;
                    rspRo_d    = port1_q ? doutRo : '0;
                end else begin
                    latCnt_d = latCnt_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (pktBus.rsp_ready) begin
                    state_d    = ST_IDLE;
                    rspValid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            latCnt_q   <= '0;
            bank_q     <= '0;
            port0_q    <= 1'b0;
            port1_q    <= 1'b0;
            write_q    <= 1'b0;
            csb0_q     <= '1;
            csb1_q     <= '1;
            web0_q     <= '1;
            wmask0_q   <= '0;
            addr0_q    <= '0;
            addr1_q    <= '0;
            din0_q     <= '0;
            rspValid_q <= 1'b0;
            rspErr_q   <= 1'b0;
            rspRw_q    <= '0;
            rspRo_q    <= '0;
        end else begin
            state_q    <= state_d;
            latCnt_q   <= latCnt_d;
            bank_q     <= bank_d;
            port0_q    <= port0_d;
            port1_q    <= port1_d;
            write_q    <= write_d;
            csb0_q     <= csb0_d;
            csb1_q     <= csb1_d;
            web0_q     <= web0_d;
            wmask0_q   <= wmask0_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            din0_q     <= din0_d;
            rspValid_q <= rspValid_d;
            rspErr_q   <= rspErr_d;
            rspRw_q    <= rspRw_d;
            rspRo_q    <= rspRo_d;
        end
    end

    assign pktBus.pkt_ready   = pktReady;
    assign pktBus.rsp_valid   = rspValid_q;
    assign pktBus.rsp_err     = rspErr_q;
    assign pktBus.rsp_data_rw = rspRw_q;
    assign pktBus.rsp_data_ro = rspRo_q;
    assign sram_csb0          = csb0_q;
    assign sram_csb1          = csb1_q;
    assign sram_web0          = web0_q;
    assign sram_wmask0        = wmask0_q;
    assign sram_addr0         = addr0_q;
    assign sram_addr1         = addr1_q;
    assign sram_din0          = din0_q;
    assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_packet_ctrl.sv
// Bench for sram_packet_ctrl with three macros (so bank 3 is out of range) and a two-edge read latency;
// a behavioural macro array answers the pins while a plain word array predicts every response.
module tb_sram_packet_ctrl;

    localparam int NUM_SRAMS    = 3;
    localparam int ADDR_WIDTH   = 8;
    localparam int DATA_WIDTH   = 32;
    localparam int MASK_WIDTH   = 4;
    localparam int READ_LATENCY = 2;
    localparam int BANK_W       = 2;
    localparam int PKT_W        = 3 + BANK_W + MASK_WIDTH + 2 * ADDR_WIDTH + DATA_WIDTH;
    localparam int DEPTH        = 1 << ADDR_WIDTH;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_RW    = 3'd2;
    localparam logic [2:0] OP_RO    = 3'd3;
    localparam logic [2:0] OP_DUAL  = 3'd4;

    logic clk;
    logic rst;
    logic [NUM_SRAMS-1:0]            sram_csb0, sram_web0, sram_csb1;
    logic [NUM_SRAMS*MASK_WIDTH-1:0] sram_wmask0;
    logic [NUM_SRAMS*ADDR_WIDTH-1:0] sram_addr0, sram_addr1;
    logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_din0;
    logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_dout0 = '0;
    logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_dout1 = '0;
    logic busy;

    bit [DATA_WIDTH-1:0] macroMem [NUM_SRAMS][DEPTH];
    bit [DATA_WIDTH-1:0] refMem   [NUM_SRAMS][DEPTH];

    int passCount  = 0;
    int checkCount = 0;

    sram_packet_ctrl_if #(.PKT_W(PKT_W), .DATA_WIDTH(DATA_WIDTH)) bus ();

    sram_packet_ctrl #(
        .NUM_SRAMS   (NUM_SRAMS),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .MASK_WIDTH  (MASK_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) dut (
        .clk_in     (clk),
        .rst        (rst),
        .pktBus     (bus),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_wmask0(sram_wmask0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro behaviour: capture on the edge where csb is low, dout then holds until the next read.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_SRAMS; i++) begin
            if (!sram_csb1[i])
                sram_dout1[i*DATA_WIDTH +: DATA_WIDTH] <= macroMem[i][sram_addr1[i*ADDR_WIDTH +: ADDR_WIDTH]];
            if (!sram_csb0[i]) begin
                if (!sram_web0[i]) begin
                    for (int b = 0; b < MASK_WIDTH; b++)
                        if (sram_wmask0[i*MASK_WIDTH + b])
                            macroMem[i][sram_addr0[i*ADDR_WIDTH +: ADDR_WIDTH]][b*8 +: 8] <= sram_din0[i*DATA_WIDTH + b*8 +: 8];
                end else begin
                    sram_dout0[i*DATA_WIDTH +: DATA_WIDTH] <= macroMem[i][sram_addr0[i*ADDR_WIDTH +: ADDR_WIDTH]];
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    endtask

    // Sends one packet and follows it to completion, checking pins cycle by cycle against the reference.
    task automatic applyStimulus(input logic [2:0] op, input int bank, input logic [MASK_WIDTH-1:0] mask,
                                 input logic [ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] wdata,
                                 input logic [ADDR_WIDTH-1:0] addrRo, input int holdCycles, input bit offerWhileBusy);
        logic [NUM_SRAMS-1:0]  ones, sel;
        logic [DATA_WIDTH-1:0] expRw, expRo;
        bit isNop, isWrite, rdRw, rdRo, illegal;
        int waited;
        ones    = '1;
        sel     = '1;
        isNop   = (op == OP_NOP);
        isWrite = (op == OP_WRITE);
        rdRw    = (op == OP_RW) || (op == OP_DUAL);
        rdRo    = (op == OP_RO) || (op == OP_DUAL);
        illegal = (op > OP_DUAL) || (!isNop && bank >= NUM_SRAMS);
        if (!illegal && !isNop) sel[bank] = 1'b0;
        expRw = '0;
        expRo = '0;
        if (!illegal && rdRw) expRw = refMem[bank][addr];
        if (!illegal && rdRo) expRo = refMem[bank][addrRo];

        bus.packet    = {op, BANK_W'(bank), mask, addr, wdata, addrRo};
        bus.pkt_valid = 1'b1;
        waited = 0;
        while (!bus.pkt_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.pkt_ready) begin
            checkOutput("acceptTimeout", 64'(bus.pkt_ready), 64'd1);
            bus.pkt_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.pkt_valid = 1'b0;

        if (isNop) begin
            checkOutput("nopBusy", 64'(busy), 64'd0);
            checkOutput("nopCsb", 64'({sram_csb0, sram_csb1}), 64'({ones, ones}));
            checkOutput("nopRsp", 64'(bus.rsp_valid), 64'd0);
            return;
        end

        if (!illegal) begin
            checkOutput("issueCsb0", 64'(sram_csb0), 64'((isWrite || rdRw) ? sel : ones));
            checkOutput("issueCsb1", 64'(sram_csb1), 64'(rdRo ? sel : ones));
            checkOutput("issueWeb0", 64'(sram_web0), 64'(isWrite ? sel : ones));
            checkOutput("issueRsp", 64'(bus.rsp_valid), 64'd0);
            if (isWrite || rdRw)
                checkOutput("issueAddr0", 64'(sram_addr0[bank*ADDR_WIDTH +: ADDR_WIDTH]), 64'(addr));
            if (rdRo)
                checkOutput("issueAddr1", 64'(sram_addr1[bank*ADDR_WIDTH +: ADDR_WIDTH]), 64'(addrRo));
            if (isWrite) begin
                checkOutput("issueDin", 64'(sram_din0[bank*DATA_WIDTH +: DATA_WIDTH]), 64'(wdata));
                checkOutput("issueMask", 64'(sram_wmask0[bank*MASK_WIDTH +: MASK_WIDTH]), 64'(mask));
            end
            @(posedge clk); #1;
            checkOutput("strobeIdle", 64'({sram_csb0, sram_csb1, sram_web0}), 64'({ones, ones, ones}));
            if (isWrite) begin
                for (int b = 0; b < MASK_WIDTH; b++)
                    if (mask[b]) refMem[bank][addr][b*8 +: 8] = wdata[b*8 +: 8];
                checkOutput("writeDoneBusy", 64'(busy), 64'd0);
                checkOutput("writeDoneReady", 64'(bus.pkt_ready), 64'd1);
                checkOutput("writeNoRsp", 64'(bus.rsp_valid), 64'd0);
                return;
            end
            for (int i = 0; i < READ_LATENCY; i++) begin
                checkOutput("rspEarly", 64'(bus.rsp_valid), 64'd0);
                @(posedge clk); #1;
            end
        end

        checkOutput("rspValid", 64'(bus.rsp_valid), 64'd1);
        checkOutput("rspErr", 64'(bus.rsp_err), 64'(illegal));
        checkOutput("rspData", {bus.rsp_data_rw, bus.rsp_data_ro}, {expRw, expRo});
        if (illegal)
            checkOutput("errNoCsb", 64'({sram_csb0, sram_csb1}), 64'({ones, ones}));

        bus.rsp_ready = 1'b0;
        for (int i = 0; i < holdCycles; i++) begin
            if (offerWhileBusy) begin
                bus.packet    = {OP_WRITE, BANK_W'(0), 4'hF, 8'h55, 32'hBAD0BAD0, 8'h00};
                bus.pkt_valid = 1'b1;
            end
            @(posedge clk); #1;
            checkOutput("holdValid", 64'(bus.rsp_valid), 64'd1);
            checkOutput("holdErr", 64'(bus.rsp_err), 64'(illegal));
            checkOutput("holdData", {bus.rsp_data_rw, bus.rsp_data_ro}, {expRw, expRo});
            checkOutput("holdNoReady", 64'(bus.pkt_ready), 64'd0);
            checkOutput("holdNoCsb", 64'(sram_csb0), 64'(ones));
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.pkt_valid = 1'b0;
        checkOutput("rspDropped", 64'(bus.rsp_valid), 64'd0);
        checkOutput("readyAfterRsp", 64'(bus.pkt_ready), 64'd1);
    endtask

    initial begin
        logic [NUM_SRAMS-1:0] allOnes;
        logic [2:0] op;
        int bank, waited;
        allOnes       = '1;
        rst           = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.packet    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetReady", 64'(bus.pkt_ready), 64'd0);
        checkOutput("resetStrobes", 64'({sram_csb0, sram_csb1, sram_web0}), 64'({allOnes, allOnes, allOnes}));
        checkOutput("resetBuses", 64'(|{sram_wmask0, sram_addr0, sram_addr1, sram_din0}), 64'd0);
        checkOutput("resetRsp", 64'({bus.rsp_valid, bus.rsp_err, busy}), 64'd0);
        checkOutput("resetData", {bus.rsp_data_rw, bus.rsp_data_ro}, 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("readyAfterReset", 64'(bus.pkt_ready), 64'd1);

        applyStimulus(OP_WRITE, 0, 4'hF, 8'h00, 32'h0000_0001, 8'h00, 0, 1'b0);
        applyStimulus(OP_RW,    0, 4'h0, 8'h00, 32'h0,         8'h00, 0, 1'b0);
        applyStimulus(OP_WRITE, 1, 4'h3, 8'h7F, 32'hDEAD_BEEF, 8'h00, 0, 1'b0);
        applyStimulus(OP_DUAL,  1, 4'h0, 8'h7F, 32'h0,         8'h7F, 0, 1'b0);
        applyStimulus(OP_RW,    3, 4'h0, 8'h10, 32'h0,         8'h00, 1, 1'b0);
        applyStimulus(3'd6,     0, 4'h0, 8'h10, 32'h0,         8'h00, 0, 1'b0);
        applyStimulus(OP_WRITE, 2, 4'hF, 8'hFF, 32'hCAFE_F00D, 8'h00, 0, 1'b0);
        applyStimulus(OP_RO,    2, 4'h0, 8'h00, 32'h0,         8'hFF, 5, 1'b1);
        applyStimulus(OP_RW,    0, 4'h0, 8'h55, 32'h0,         8'h00, 0, 1'b0);

        // Abort a read while it waits on the macro latency.
        bus.packet    = {OP_RW, BANK_W'(2), 4'h0, 8'hFF, 32'h0, 8'h00};
        bus.pkt_valid = 1'b1;
        waited = 0;
        while (!bus.pkt_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("abortAccept", 64'(bus.pkt_ready), 64'd1);
        @(posedge clk); #1;
        bus.pkt_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("abortInWait", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("abortReady", 64'(bus.pkt_ready), 64'd0);
        checkOutput("abortBusy", 64'(busy), 64'd0);
        checkOutput("abortAddr", 64'(sram_addr0[2*ADDR_WIDTH +: ADDR_WIDTH]), 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("abortReadyAfter", 64'(bus.pkt_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checkOutput("abortNoRsp", 64'(bus.rsp_valid), 64'd0);
            checkOutput("abortNoCsb", 64'({sram_csb0, sram_csb1}), 64'({allOnes, allOnes}));
        end

        for (int n = 0; n < 60; n++) begin
            op   = 3'($urandom_range(0, 7));
            bank = (op == OP_NOP) ? $urandom_range(0, NUM_SRAMS - 1) : $urandom_range(0, 3);
            applyStimulus(op, bank, 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7)),
                          $urandom, 8'($urandom_range(0, 7)), $urandom_range(0, 3), 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
